// File: rtl/rate_controller_if.sv
// Handshake and rate bus between the angle stage (master) and the rate controller (slave).
interface rate_controller_if;
    logic               start_signal;
    logic               active_signal;
    logic               complete_signal;
    logic signed [15:0] throttle_rate;
    logic signed [15:0] yaw_rate_target;
    logic signed [15:0] pitch_rate_target;
    logic signed [15:0] roll_rate_target;
    logic signed [15:0] yaw_rate_actual;
    logic signed [15:0] pitch_rate_actual;
    logic signed [15:0] roll_rate_actual;
    logic signed [15:0] throttle_rate_out;
    logic signed [15:0] yaw_rate_out;
    logic signed [15:0] pitch_rate_out;
    logic signed [15:0] roll_rate_out;

    modport master (
        output start_signal, throttle_rate,
        output yaw_rate_target, pitch_rate_target, roll_rate_target,
        output yaw_rate_actual, pitch_rate_actual, roll_rate_actual,
        input  active_signal, complete_signal,
        input  throttle_rate_out, yaw_rate_out, pitch_rate_out, roll_rate_out
    );

    modport slave (
        input  start_signal, throttle_rate,
        input  yaw_rate_target, pitch_rate_target, roll_rate_target,
        input  yaw_rate_actual, pitch_rate_actual, roll_rate_actual,
        output active_signal, complete_signal,
        output throttle_rate_out, yaw_rate_out, pitch_rate_out, roll_rate_out
    );
endinterface

// File: rtl/rate_controller.sv
// Three-axis PI rate controller, Q12.4 fixed point, one update per start request (6-cycle pipeline FSM).
// Define RATE_INTEGRAL_EN to build the integrator path; without it the controller is P-only.
module rate_controller #(
    parameter logic signed [15:0] KP           = 16'sh0020,
    parameter int                 KI_SHIFT     = 3,
    parameter logic signed [15:0] I_LIMIT      = 16'sh0320,
    parameter logic signed [15:0] OUT_LIMIT    = 16'sh0C80,
    parameter logic signed [15:0] THROTTLE_MAX = 16'sh0FA0
) (
    input  logic              us_clk,
    input  logic              resetn,
    rate_controller_if.slave  bus
);

    typedef enum logic [6:0] {
        WAITING  = 7'b000_0001,
        LATCH    = 7'b000_0010,
        ERROR    = 7'b000_0100,
        SCALE    = 7'b000_1000,
        ACCUM    = 7'b001_0000,
        LIMIT    = 7'b010_0000,
        COMPLETE = 7'b100_0000
    } state_t;

    state_t             state_reg;
    logic               active_reg;
    logic               complete_reg;
    logic signed [15:0] thr_lat_reg;
    logic signed [15:0] thr_out_reg;

    // Axis order everywhere: 0 = yaw, 1 = pitch, 2 = roll.
    logic signed [15:0] tgt_in   [3];
    logic signed [15:0] act_in   [3];
    logic signed [15:0] rate_out [3];

    assign tgt_in[0] = bus.yaw_rate_target;
    assign tgt_in[1] = bus.pitch_rate_target;
    assign tgt_in[2] = bus.roll_rate_target;
    assign act_in[0] = bus.yaw_rate_actual;
    assign act_in[1] = bus.pitch_rate_actual;
    assign act_in[2] = bus.roll_rate_actual;

    assign bus.yaw_rate_out      = rate_out[0];
    assign bus.pitch_rate_out    = rate_out[1];
    assign bus.roll_rate_out     = rate_out[2];
    assign bus.throttle_rate_out = thr_out_reg;
    assign bus.active_signal     = active_reg;
    assign bus.complete_signal   = complete_reg;

    if (KI_SHIFT < 0 || KI_SHIFT > 15 || I_LIMIT < 16'sd0 || OUT_LIMIT < 16'sd0) begin : g_bad_param
        $error("rate_controller: KI_SHIFT must be 0..15 and limits non-negative");
    end

    function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return 16'sh7FFF;
        if (v < -17'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] sat32(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        if (v < -32'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] clamp17(input logic signed [16:0] v,
                                                    input logic signed [15:0] lim);
        logic signed [16:0] lim17;
        lim17 = {lim[15], lim};
        if (v > lim17)
            return lim;
        if (v < -lim17)
            return -lim;
        return v[15:0];
    endfunction

    // Control FSM; active/complete are registered from the state being entered.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state_reg    <= WAITING;
            active_reg   <= 1'b0;
            complete_reg <= 1'b0;
        end else begin
            case (state_reg)
                WAITING: begin
                    complete_reg <= 1'b0;
                    if (bus.start_signal) begin
                        state_reg  <= LATCH;
                        active_reg <= 1'b1;
                    end else begin
                        state_reg  <= WAITING;
                        active_reg <= 1'b0;
                    end
                end
                LATCH: begin
                    state_reg    <= ERROR;
                    active_reg   <= 1'b1;
                    complete_reg <= 1'b0;
                end
                ERROR: begin
                    state_reg    <= SCALE;
                    active_reg   <= 1'b1;
                    complete_reg <= 1'b0;
                end
                SCALE: begin
                    state_reg    <= ACCUM;
                    active_reg   <= 1'b1;
                    complete_reg <= 1'b0;
                end
                ACCUM: begin
                    state_reg    <= LIMIT;
                    active_reg   <= 1'b1;
                    complete_reg <= 1'b0;
                end
                LIMIT: begin
                    state_reg    <= COMPLETE;
                    active_reg   <= 1'b0;
                    complete_reg <= 1'b1;
                end
                COMPLETE: begin
                    state_reg    <= WAITING;
                    active_reg   <= 1'b0;
                    complete_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= WAITING;
                    active_reg   <= 1'b0;
                    complete_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            thr_lat_reg <= '0;
            thr_out_reg <= '0;
        end else begin
            if (state_reg == LATCH)
                thr_lat_reg <= bus.throttle_rate;
            if (state_reg == LIMIT) begin
                if (thr_lat_reg < 16'sd0)
                    thr_out_reg <= '0;
                else if (thr_lat_reg > THROTTLE_MAX)
                    thr_out_reg <= THROTTLE_MAX;
                else
                    thr_out_reg <= thr_lat_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic signed [15:0] tgt_lat_reg;
        logic signed [15:0] act_lat_reg;
        logic signed [15:0] err_reg;
        logic signed [15:0] p_reg;
        logic signed [15:0] out_reg;
        logic signed [15:0] i_new;
        logic signed [16:0] diff;
        logic signed [31:0] err_ext;
        logic signed [31:0] kp_ext;
        logic signed [31:0] prod_sh;
        logic signed [16:0] out_sum;

        assign diff    = {tgt_lat_reg[15], tgt_lat_reg} - {act_lat_reg[15], act_lat_reg};
        assign err_ext = {{16{err_reg[15]}}, err_reg};
        assign kp_ext  = {{16{KP[15]}}, KP};
        assign prod_sh = (err_ext * kp_ext) >>> 4;
        assign out_sum = {p_reg[15], p_reg} + {i_new[15], i_new};

`ifdef RATE_INTEGRAL_EN
        logic signed [15:0] integ_reg;
        logic signed [15:0] step;
        logic signed [16:0] integ_sum;

        assign step      = err_reg >>> KI_SHIFT;
        assign integ_sum = {integ_reg[15], integ_reg} + {step[15], step};

        // Integrators are held at zero while the throttle is not positive (motors idle).
        always_ff @(posedge us_clk) begin
            if (!resetn)
                integ_reg <= '0;
            else if (state_reg == ACCUM)
                integ_reg <= (thr_lat_reg <= 16'sd0) ? 16'sd0 : clamp17(integ_sum, I_LIMIT);
        end

        assign i_new = integ_reg;
`else
        assign i_new = '0;
`endif

        always_ff @(posedge us_clk) begin
            if (!resetn) begin
                tgt_lat_reg <= '0;
                act_lat_reg <= '0;
                err_reg     <= '0;
                p_reg       <= '0;
                out_reg     <= '0;
            end else begin
                if (state_reg == LATCH) begin
                    tgt_lat_reg <= tgt_in[gi];
                    act_lat_reg <= act_in[gi];
                end
                if (state_reg == ERROR)
                    err_reg <= sat17(diff);
                if (state_reg == SCALE)
                    p_reg <= sat32(prod_sh);
                if (state_reg == LIMIT)
                    out_reg <= clamp17(out_sum, OUT_LIMIT);
            end
        end

        assign rate_out[gi] = out_reg;
    end

endmodule

// File: tb/tb_rate_controller.sv
// Directed self-checking bench for rate_controller; expectations follow RATE_INTEGRAL_EN if defined.
module tb_rate_controller;

`ifdef RATE_INTEGRAL_EN
    localparam bit INTEG = 1'b1;
`else
    localparam bit INTEG = 1'b0;
`endif

    logic us_clk = 1'b0;
    logic resetn = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    rate_controller_if bus_if ();

    rate_controller dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    always #5 us_clk = ~us_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [15:0] thr,
                              input logic [15:0] yt, input logic [15:0] ya,
                              input logic [15:0] pt, input logic [15:0] pa,
                              input logic [15:0] rt, input logic [15:0] ra);
        bus_if.throttle_rate     = thr;
        bus_if.yaw_rate_target   = yt;
        bus_if.yaw_rate_actual   = ya;
        bus_if.pitch_rate_target = pt;
        bus_if.pitch_rate_actual = pa;
        bus_if.roll_rate_target  = rt;
        bus_if.roll_rate_actual  = ra;
    endtask

    task automatic scramble();
        set_inputs(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // One start pulse; checks active/complete per cycle and scrambles inputs once latched.
    task automatic do_update(input string tag);
        @(negedge us_clk);
        bus_if.start_signal = 1'b1;
        @(posedge us_clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge us_clk);
            if (k == 1)
                bus_if.start_signal = 1'b0;
            if (k == 2)
                scramble();
            check($sformatf("%s active k%0d", tag, k), {15'd0, bus_if.active_signal},
                  {15'd0, (k <= 5)});
            check($sformatf("%s complete k%0d", tag, k), {15'd0, bus_if.complete_signal},
                  {15'd0, (k == 6)});
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] thr, input logic [15:0] y,
                              input logic [15:0] p, input logic [15:0] r);
        check({tag, " throttle"}, bus_if.throttle_rate_out, thr);
        check({tag, " yaw"},      bus_if.yaw_rate_out,      y);
        check({tag, " pitch"},    bus_if.pitch_rate_out,    p);
        check({tag, " roll"},     bus_if.roll_rate_out,     r);
    endtask

    initial begin
        int pulses;
        int t_first;
        int t_pulse [3];

        bus_if.start_signal = 1'b0;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge us_clk);
        @(negedge us_clk);
        expect_out("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        check("reset active",   {15'd0, bus_if.active_signal},   16'h0);
        check("reset complete", {15'd0, bus_if.complete_signal}, 16'h0);
        resetn = 1'b1;

        // Yaw error 12.0: P = 24.0, first integral step 1.5
        set_inputs(16'h0500, 16'h0100, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("yaw_basic");
        expect_out("yaw_basic", 16'h0500, INTEG ? 16'h0198 : 16'h0180, 16'h0, 16'h0);

        // Pitch error +200: P saturates the output clamp
        set_inputs(16'h0500, 16'h0, 16'h0, 16'h0640, 16'hF9C0, 16'h0, 16'h0);
        do_update("pitch_pos");
        expect_out("pitch_pos", 16'h0500, INTEG ? 16'h0018 : 16'h0, 16'h0C80, 16'h0);

        set_inputs(16'h0500, 16'h0, 16'h0, 16'hF9C0, 16'h0640, 16'h0, 16'h0);
        do_update("pitch_neg");
        expect_out("pitch_neg", 16'h0500, INTEG ? 16'h0018 : 16'h0, 16'hF380, 16'h0);

        // Negative throttle: output 0 and integrators cleared (yaw is P-only)
        set_inputs(16'hFFF0, 16'h0100, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("thr_neg");
        expect_out("thr_neg", 16'h0, 16'h0180, 16'h0, 16'h0);

        set_inputs(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("thr_ceil");
        expect_out("thr_ceil", 16'h0FA0, 16'h0, 16'h0, 16'h0);

        // Small negative roll error -2.0: P = -4.0, integral step -0.25
        set_inputs(16'h0500, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFF0, 16'h0010);
        do_update("roll_small_neg");
        expect_out("roll_small_neg", 16'h0500, 16'h0, 16'h0, INTEG ? 16'hFFBC : 16'hFFC0);

        // Error difference overflows 16 bits and must saturate, not wrap
        set_inputs(16'h0500, 16'h7000, 16'h9000, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("err_sat_pos");
        expect_out("err_sat_pos", 16'h0500, 16'h0C80, 16'h0, INTEG ? 16'hFFFC : 16'h0);

        set_inputs(16'h0500, 16'h9000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("err_sat_neg");
        expect_out("err_sat_neg", 16'h0500, 16'hF380, 16'h0, INTEG ? 16'hFFFC : 16'h0);

        // Roll error 16.0 held: integrator climbs by 2.0 per update to its 50.0 clamp
        set_inputs(16'h0500, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0);
        do_update("roll_integ_1");
        expect_out("roll_integ_1", 16'h0500, INTEG ? 16'hFCE0 : 16'h0, 16'h0,
                   INTEG ? 16'h021C : 16'h0200);
        for (int n = 2; n <= 30; n++) begin
            set_inputs(16'h0500, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0);
            do_update($sformatf("roll_integ_%0d", n));
        end
        expect_out("roll_integ_sat", 16'h0500, INTEG ? 16'hFCE0 : 16'h0, 16'h0,
                   INTEG ? 16'h0520 : 16'h0200);

        set_inputs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("integ_clear");
        expect_out("integ_clear", 16'h0, 16'h0, 16'h0, 16'h0);

        // Start held high: three updates, completes 7 cycles apart
        set_inputs(16'h0500, 16'h0100, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
        pulses = 0;
        t_pulse[0] = 0; t_pulse[1] = 0; t_pulse[2] = 0;
        @(negedge us_clk);
        bus_if.start_signal = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge us_clk);
            if (bus_if.complete_signal === 1'b1) begin
                if (pulses < 3)
                    t_pulse[pulses] = c;
                pulses++;
                if (pulses == 3)
                    bus_if.start_signal = 1'b0;
            end
        end
        bus_if.start_signal = 1'b0;
        check("held pulses", 16'(pulses), 16'd3);
        check("held gap1", 16'(t_pulse[1] - t_pulse[0]), 16'd7);
        check("held gap2", 16'(t_pulse[2] - t_pulse[1]), 16'd7);

        // Second start pulse during ERROR is ignored
        pulses  = 0;
        t_first = 0;
        @(negedge us_clk);
        bus_if.start_signal = 1'b1;
        @(posedge us_clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge us_clk);
            bus_if.start_signal = (k == 2);
            if (bus_if.complete_signal === 1'b1) begin
                if (pulses == 0)
                    t_first = k;
                pulses++;
            end
        end
        bus_if.start_signal = 1'b0;
        check("ignored start pulses", 16'(pulses), 16'd1);
        check("ignored start latency", 16'(t_first), 16'd6);

        // Reset during SCALE aborts the update
        set_inputs(16'h0500, 16'h0100, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge us_clk);
        bus_if.start_signal = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        bus_if.start_signal = 1'b0;
        @(negedge us_clk);
        @(negedge us_clk);
        check("pre_abort active", {15'd0, bus_if.active_signal}, 16'h1);
        resetn = 1'b0;
        @(negedge us_clk);
        resetn = 1'b1;
        expect_out("abort", 16'h0, 16'h0, 16'h0, 16'h0);
        check("abort active", {15'd0, bus_if.active_signal}, 16'h0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge us_clk);
            if (bus_if.complete_signal === 1'b1)
                pulses++;
        end
        check("abort no complete", 16'(pulses), 16'd0);

        set_inputs(16'h0500, 16'h0100, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0);
        do_update("post_abort");
        expect_out("post_abort", 16'h0500, INTEG ? 16'h0198 : 16'h0180, 16'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
